// File: rtl/decim_pkg.sv
// Shared definitions for the decimation controller: FSM encoding, rate-code
// decoding and reset constants.
package decim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FRST   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam logic [3:0]  MAX_RATE_CODE = 4'd7;
  localparam logic [15:0] RESET_RATE    = 16'd256;
  localparam logic [15:0] BASE_RATE     = 16'd32;

  function automatic logic code_legal(input logic [3:0] code);
    return code <= MAX_RATE_CODE;
  endfunction

  function automatic logic [15:0] rate_of(input logic [3:0] code);
    return BASE_RATE << code;
  endfunction

endpackage

// File: rtl/decim_out_buf.sv
// Single-entry output register with sticky overrun flag.
// Optional DECIM_CTRL_OVRCNT_EN adds a saturating dropped-word counter.
module decim_out_buf (
  input  logic        mclk1,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
`ifdef DECIM_CTRL_OVRCNT_EN
  output logic [15:0] ovr_count,
`endif
  output logic        overrun
);

  logic handshake;
  logic accept_word;

  assign handshake   = out_valid & out_ready;
  // A word is taken when the slot is empty or is being emptied this same cycle.
  assign accept_word = load & (~out_valid | handshake);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge mclk1) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept_word) begin
        out_data  <= load_data;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
      if (load && !accept_word) overrun <= 1'b1;
    end
  end

`ifdef DECIM_CTRL_OVRCNT_EN
  always_ff @(posedge mclk1) begin
    if (reset || clear) begin
      ovr_count <= '0;
    end else if (load && !accept_word && ovr_count != 16'hFFFF) begin
      ovr_count <= ovr_count + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/decim_ctrl.sv
// Decimation filter controller: config handshake, filter reset/settle
// sequencing and a single-entry output stream. Optional: DECIM_CTRL_OVRCNT_EN.
module decim_ctrl
  import decim_pkg::*;
#(
  parameter int RST_CYCLES   = 4,
  parameter int SETTLE_WORDS = 3
) (
  input  logic        mclk1,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [3:0]  cfg_rate_code,
  output logic        cfg_err,
  output logic        filt_reset,
  output logic [15:0] dec_rate,
  input  logic [15:0] filt_data,
  input  logic        filt_data_en,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun,
`ifdef DECIM_CTRL_OVRCNT_EN
  output logic [15:0] ovr_count,
`endif
  output logic [1:0]  state
);

  localparam int FRST_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SETTLE_W = (SETTLE_WORDS > 1) ? $clog2(SETTLE_WORDS) : 1;
  localparam bit SKIP_SETTLE = (SETTLE_WORDS == 0);
  localparam logic [FRST_W-1:0]   FRST_LAST   = FRST_W'(RST_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SKIP_SETTLE ? 0 : SETTLE_WORDS - 1);

  state_t              cur_st;
  logic [FRST_W-1:0]   frst_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                cfg_fire;
  logic                cfg_go;
  logic                cfg_bad;
  logic                buf_load;

  assign cfg_ready  = (cur_st != ST_FRST);
  assign filt_reset = (cur_st == ST_IDLE) || (cur_st == ST_FRST);
  assign state      = cur_st;

  assign cfg_fire = cfg_valid & cfg_ready;
  assign cfg_go   = cfg_fire & code_legal(cfg_rate_code);
  assign cfg_bad  = cfg_fire & ~code_legal(cfg_rate_code);
  // A restart wins over a strobe landing in the same cycle.
  assign buf_load = filt_data_en & (cur_st == ST_RUN) & ~cfg_go;

  always_ff @(posedge mclk1) begin
    if (reset) begin
      cur_st     <= ST_IDLE;
      dec_rate   <= RESET_RATE;
      cfg_err    <= 1'b0;
      frst_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      cfg_err <= cfg_bad;
      if (cfg_go) begin
        dec_rate   <= rate_of(cfg_rate_code);
        cur_st     <= ST_FRST;
        frst_cnt   <= '0;
        settle_cnt <= '0;
      end else begin
        case (cur_st)
          ST_FRST: begin
            if (frst_cnt == FRST_LAST) begin
              frst_cnt <= '0;
              cur_st   <= SKIP_SETTLE ? ST_RUN : ST_SETTLE;
            end else begin
              frst_cnt <= frst_cnt + FRST_W'(1);
            end
          end
          ST_SETTLE: begin
            if (filt_data_en) begin
              if (settle_cnt == SETTLE_LAST) begin
                settle_cnt <= '0;
                cur_st     <= ST_RUN;
              end else begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  decim_out_buf u_out_buf (
    .mclk1     (mclk1),
    .reset     (reset),
    .clear     (cfg_go),
    .load      (buf_load),
    .load_data (filt_data),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef DECIM_CTRL_OVRCNT_EN
    .ovr_count (ovr_count),
`endif
    .overrun   (overrun)
  );

endmodule

// File: doc/decim_ctrl.md
DECIM_CTRL -- requirements
Module: decim_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4: cycles filt_reset is held per (re)start.
REQ-002 SHALL have parameter SETTLE_WORDS, default 3: filter output words discarded after each (re)start.
REQ-003 SHALL have port mclk1  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports cfg_valid in 1 / cfg_ready out 1  config request handshake.
REQ-006 SHALL have port cfg_rate_code  in  4  decimation code; rate = 32 << code; legal codes 0..7.
REQ-007 SHALL have port cfg_err  out  1  one-cycle pulse on an illegal code.
REQ-008 SHALL have port filt_reset  out  1  reset to the decimation filter.
REQ-009 SHALL have port dec_rate  out  16  decimation rate to the filter.
REQ-010 SHALL have ports filt_data in 16 / filt_data_en in 1  filter output word and its one-cycle strobe.
REQ-011 SHALL have ports out_data out 16 / out_valid out 1 / out_ready in 1  downstream valid/ready stream.
REQ-012 SHALL have port overrun  out  1  sticky flag: a word was dropped.
REQ-013 SHALL have port state  out  2  current FSM state encoding.

Function
REQ-014 FSM states SHALL be IDLE=0, FRST=1, SETTLE=2, RUN=3.
REQ-015 IDLE: filt_reset=1, cfg_ready=1; accepted legal cfg (cfg_valid&cfg_ready) latches rate into dec_rate and goes to FRST next cycle.
REQ-016 FRST: filt_reset=1 for exactly RST_CYCLES cycles, then SETTLE; cfg_ready=0.
REQ-017 SETTLE: filt_reset=0; count filt_data_en pulses; the first SETTLE_WORDS words are discarded; the state changes to RUN on the cycle after the last discarded strobe.
REQ-018 RUN: each filt_data_en captures filt_data into out_data and sets out_valid the next cycle.
REQ-019 out_valid SHALL clear on the out_valid&out_ready handshake; out_data SHALL hold stable while out_valid=1 and not accepted.
REQ-020 A strobe arriving while out_valid=1 and not accepted in that same cycle SHALL be dropped, set overrun, and leave out_data unchanged; handshake plus strobe in the same cycle SHALL load the new word with out_valid staying 1.
REQ-021 cfg_ready SHALL be 1 in IDLE, SETTLE and RUN; an accepted legal cfg in SETTLE/RUN SHALL update dec_rate, clear out_valid, and restart in FRST.
REQ-022 An illegal code (8..15) with cfg_valid&cfg_ready SHALL pulse cfg_err for one cycle and change no other state or output.
REQ-023 overrun SHALL be cleared only by reset or by an accepted legal cfg.
REQ-024 Settle counter and FRST counter SHALL be sized for their parameters; neither wraps.

Reset
REQ-025 On reset: state=IDLE, filt_reset=1, dec_rate=16'd256, out_data=0, out_valid=0, overrun=0, cfg_err=0, counters=0.
REQ-026 reset asserted mid-operation SHALL take precedence over cfg and strobes in that cycle.

Configuration
REQ-027 Macro DECIM_CTRL_OVRCNT_EN, when defined, SHALL add output ovr_count[15:0]: count of dropped words, saturating at 16'hFFFF, cleared like overrun.
REQ-028 Without DECIM_CTRL_OVRCNT_EN, port ovr_count and its counter SHALL not exist; all other behaviour is identical.

Structure
REQ-029 A shared package decim_pkg SHALL hold the state enum, the rate-code-to-rate function, the legal-code maximum (7), and the reset rate (256).
REQ-030 One sub-module decim_out_buf SHALL implement the single-entry output register with the overrun logic; the FSM stays in decim_ctrl.

Verification
REQ-031 Reset, then cfg code 3 -> dec_rate=256, filt_reset high 4 cycles, then 3 strobes discarded, 4th strobe word appears on out_data with out_valid=1.
REQ-032 RUN, out_ready=0, two strobes (0x1234, 0x5678) -> out_data=0x1234, overrun=1 (ovr_count=1 if enabled).
REQ-033 RUN, strobe and out_ready handshake in the same cycle -> new word loaded, out_valid stays 1, overrun=0.
REQ-034 cfg code 9 in RUN -> cfg_err one-cycle pulse, dec_rate and state unchanged.
REQ-035 cfg code 7 in RUN with out_valid=1 -> dec_rate=4096, out_valid=0, state=FRST next cycle, overrun cleared.
REQ-036 reset asserted in SETTLE with cfg_valid high -> all reset values next cycle, cfg ignored.
